// File: rtl/lab2_tecmidi_mem_pkg.sv
// Shared constants for the TecMIDI on-chip RAM arbiter.
package lab2_tecmidi_mem_pkg;

  localparam int unsigned ADDR_W_DEF   = 12;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_LOCK_DEF = 8;

  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

endpackage

// File: rtl/lab2_tecmidi_rr_arb2.sv
// Two-way round-robin arbiter core with a bounded grant lock for requester 1.
module lab2_tecmidi_rr_arb2
  import lab2_tecmidi_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic [7:0] cnt_max,
  output logic [1:0] gnt
);

  logic       r_last_gnt;
  logic [7:0] r_lock_cnt;
  logic       w_hold;

  always_comb begin
    gnt    = 2'b00;
    w_hold = lock && (r_last_gnt == MASTER_M1) && (r_lock_cnt < cnt_max);
    if (!reset) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention: m1 keeps a locked burst, otherwise alternate.
        2'b11:   gnt = (w_hold || (r_last_gnt == MASTER_M0)) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= MASTER_M1;
      r_lock_cnt <= 8'd0;
    end else begin
      if (gnt[1]) begin
        r_last_gnt <= MASTER_M1;
      end else if (gnt[0]) begin
        r_last_gnt <= MASTER_M0;
      end
      if (!lock || gnt[0]) begin
        r_lock_cnt <= 8'd0;
      end else if (gnt[1] && req[0]) begin
        r_lock_cnt <= r_lock_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lab2_tecmidi_onchip_mem_arbiter.sv
// Arbitrates the Nios data master (m0) and the MIDI sample fetcher (m1) onto one
// single-port RAM, steering the 1-cycle read response back to the owner.
module lab2_tecmidi_onchip_mem_arbiter
  import lab2_tecmidi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  input  logic                  m1_lock,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_rd_gnt;
  logic       r_rd_pend;
  logic       r_rd_owner;

  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  lab2_tecmidi_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (w_req),
    .lock    (m1_lock),
    .cnt_max (8'(MAX_LOCK)),
    .gnt     (w_gnt)
  );

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (w_gnt[1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (w_gnt[0]) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end
  end

  assign mem_chipselect = |w_gnt;
  assign mem_clken      = 1'b1;
  assign w_rd_gnt       = mem_chipselect & ~mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= MASTER_M0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_owner <= w_gnt[1];
      end
    end
  end

  assign m0_waitrequest = reset | (w_req[0] & ~w_gnt[0]);
  assign m1_waitrequest = reset | (w_req[1] & ~w_gnt[1]);

  // Gating with reset drops a response that was in flight when reset arrived.
  assign m0_readdatavalid = r_rd_pend & ~reset & (r_rd_owner == MASTER_M0);
  assign m1_readdatavalid = r_rd_pend & ~reset & (r_rd_owner == MASTER_M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_lab2_tecmidi_onchip_mem_arbiter.sv
// Directed and randomized check of the arbiter against a cycle-level rule model.
module tb_lab2_tecmidi_onchip_mem_arbiter;

  localparam int MAX_LOCK = 8;

  logic        clk;
  logic        reset;
  logic [11:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;

  lab2_tecmidi_onchip_mem_arbiter #(
    .ADDR_W   (12),
    .DATA_W   (32),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_lock          (m1_lock),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM environment driven only by the DUT's mem_* outputs.
  logic [31:0] ram [4096];
  logic [31:0] ram_q;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    logic [31:0] t;
    if (mem_chipselect) begin
      if (mem_write) begin
        t = ram[mem_address];
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) t[8*b +: 8] = mem_writedata[8*b +: 8];
        end
        ram[mem_address] <= t;
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  typedef struct {
    int          owner;
    logic [31:0] data;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          m_last;
  int          m_cnt;
  logic [31:0] m_mem [4096];
  rsp_t        rsp_q[$];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; m1_lock = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  // One clock cycle: predict, compare combinational and response outputs, then advance model.
  task automatic step();
    int   win;
    bit   rq0, rq1, ev0, ev1;
    logic [31:0] ed;
    rsp_t r;
    #1;
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    win = -1;
    if (!reset) begin
      if (rq0 && !rq1) win = 0;
      else if (rq1 && !rq0) win = 1;
      else if (rq0 && rq1) begin
        if (m1_lock && m_last == 1 && m_cnt < MAX_LOCK) win = 1;
        else win = (m_last == 1) ? 0 : 1;
      end
    end
    chk("wait0", m0_waitrequest, reset ? 1 : (rq0 && win != 0));
    chk("wait1", m1_waitrequest, reset ? 1 : (rq1 && win != 1));
    chk("chipselect", mem_chipselect, win >= 0);
    chk("clken", mem_clken, 1);
    if (win == 0) begin
      chk("addr0", mem_address, m0_address);
      chk("write0", mem_write, m0_write);
      chk("be0", mem_byteenable, m0_byteenable);
      if (m0_write) chk("wdata0", mem_writedata, m0_writedata);
    end else if (win == 1) begin
      chk("addr1", mem_address, m1_address);
      chk("write1", mem_write, m1_write);
      chk("be1", mem_byteenable, m1_byteenable);
      if (m1_write) chk("wdata1", mem_writedata, m1_writedata);
    end
    ev0 = 0; ev1 = 0; ed = '0;
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      if (!reset) begin
        ev0 = (r.owner == 0);
        ev1 = (r.owner == 1);
        ed  = r.data;
      end
    end
    chk("rdvalid0", m0_readdatavalid, ev0);
    chk("rdvalid1", m1_readdatavalid, ev1);
    if (ev0) chk("rdata0", m0_readdata, ed);
    if (ev1) chk("rdata1", m1_readdata, ed);
    @(posedge clk);
    if (reset) begin
      m_last = 1;
      m_cnt  = 0;
    end else begin
      if (win >= 0) m_last = win;
      if (!m1_lock || win == 0) m_cnt = 0;
      else if (win == 1 && rq0) m_cnt++;
      if (win == 0) begin
        if (m0_write) m_mem[m0_address] = merge(m_mem[m0_address], m0_writedata, m0_byteenable);
        else rsp_q.push_back('{0, m_mem[m0_address]});
      end else if (win == 1) begin
        if (m1_write) m_mem[m1_address] = merge(m_mem[m1_address], m1_writedata, m1_byteenable);
        else rsp_q.push_back('{1, m_mem[m1_address]});
      end
    end
    @(negedge clk);
  endtask

  logic [11:0] pat;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
    ram_q  = '0;
    m_last = 1;
    m_cnt  = 0;
    idle();
    reset = 1;
    @(negedge clk);

    // 1: reads held through reset, m0 first afterwards.
    m0_read = 1; m0_address = 12'h001;
    m1_read = 1; m1_address = 12'h002;
    repeat (3) step();
    reset = 0;
    #1;
    chk("t1_wait_pair", {m1_waitrequest, m0_waitrequest}, 2'b10);
    step();

    // 2: m0 write then read back.
    idle();
    m0_write = 1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF;
    step();
    idle();
    m0_read = 1; m0_address = 12'h010;
    step();
    idle();
    #1;
    chk("t2_valid0", m0_readdatavalid, 1);
    chk("t2_valid1", m1_readdatavalid, 0);
    chk("t2_data", m0_readdata, 32'hDEADBEEF);
    step();

    // 3: continuous contention without lock.
    m0_read = 1; m0_address = 12'h010;
    m1_read = 1; m1_address = 12'h011;
    repeat (8) step();

    // 4: locked burst; last grant m0 so m1 starts the burst.
    idle();
    m0_read = 1; m0_address = 12'h003;
    step();
    m1_read = 1; m1_address = 12'h004; m1_lock = 1;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      pat[i] = ~m1_waitrequest;
      step();
    end
    chk("t4_grant_pattern", pat, 12'hEFF);

    // 5: read+write from m1 acts as a byte-lane write.
    idle();
    m0_write = 1; m0_address = 12'h020; m0_writedata = 32'h11223344;
    step();
    idle();
    m1_read = 1; m1_write = 1; m1_address = 12'h020;
    m1_byteenable = 4'b0010; m1_writedata = 32'h0000AB00;
    step();
    idle();
    m1_read = 1; m1_address = 12'h020;
    step();
    idle();
    #1;
    chk("t5_valid1", m1_readdatavalid, 1);
    chk("t5_data", m1_readdata, 32'h1122AB44);
    step();

    // 6: reset the cycle after an m1 read is granted.
    m1_read = 1; m1_address = 12'h010;
    step();
    reset = 1;
    m0_read = 1; m0_address = 12'h011;
    #1;
    chk("t6_valid1_dropped", m1_readdatavalid, 0);
    step();
    reset = 0;
    #1;
    chk("t6_wait_pair", {m1_waitrequest, m0_waitrequest}, 2'b10);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      m0_read       = ($urandom_range(0, 7) != 0);
      m0_write      = ($urandom_range(0, 3) == 0);
      m1_read       = ($urandom_range(0, 7) != 0);
      m1_write      = ($urandom_range(0, 3) == 0);
      m1_lock       = ($urandom_range(0, 3) != 0);
      m0_address    = 12'($urandom_range(0, 15));
      m1_address    = 12'($urandom_range(0, 15));
      m0_byteenable = 4'($urandom);
      m1_byteenable = 4'($urandom);
      m0_writedata  = $urandom;
      m1_writedata  = $urandom;
      step();
    end
    reset = 0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
